// File: rtl/ahblite_interconnect_pkg.sv
// ahblite_interconnect_pkg
// Shared definitions for the AHB-Lite interconnect:
//   - NUM_SLAVES : number of decoded slaves
//   - sel_t      : data-phase select encoding (S0..S3, DEF = internal default slave)
//   - dflt_state_t : default-slave FSM states
//   - DEF_Sn_BASE / DEF_Sn_MASK : default memory map
//   - addr_match : masked address compare used by the decoder
package ahblite_interconnect_pkg;

    localparam int NUM_SLAVES = 4;

    typedef enum logic [2:0] {
        SEL_S0  = 3'd0,
        SEL_S1  = 3'd1,
        SEL_S2  = 3'd2,
        SEL_S3  = 3'd3,
        SEL_DEF = 3'd4
    } sel_t;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } dflt_state_t;

    localparam logic [31:0] DEF_S0_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_S0_MASK = 32'hFFFF_0000;
    localparam logic [31:0] DEF_S1_BASE = 32'h2000_0000;
    localparam logic [31:0] DEF_S1_MASK = 32'hFFFF_0000;
    localparam logic [31:0] DEF_S2_BASE = 32'h4000_0000;
    localparam logic [31:0] DEF_S2_MASK = 32'hFFFF_FF00;
    localparam logic [31:0] DEF_S3_BASE = 32'h4000_0100;
    localparam logic [31:0] DEF_S3_MASK = 32'hFFFF_FF00;

    function automatic logic addr_match(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/ahblite_interconnect_default_slave.sv
// ahblite_default_slave
// Internal default slave answering every active transfer to an unmapped
// address with a two-cycle ERROR response (HREADYOUT=0/HRESP=1, then
// HREADYOUT=1/HRESP=1). IDLE/BUSY transfers complete OKAY with no wait.
// Ports:
//   HCLK, HRESETn : clock, synchronous active-low reset
//   HSEL          : decoder selects the default slave (no map hit)
//   HTRANS        : master transfer type, bit 1 marks an active transfer
//   HREADY        : muxed bus ready (address phase accepted when high)
//   HREADYOUT     : registered ready of the default slave
//   HRESP         : registered response of the default slave
//   state         : current FSM state, exposed for observation
module ahblite_default_slave
    import ahblite_interconnect_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output dflt_state_t state
);

    logic new_err;
    logic unused_htrans0;

    // An active transfer to the default slave is accepted only when the bus
    // is ready; HWRITE is irrelevant, reads and writes both error.
    assign new_err        = HSEL && HTRANS[1] && HREADY;
    assign unused_htrans0 = HTRANS[0];

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= DS_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (new_err) begin
                        state     <= DS_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= 1'b1;
                    end
                end
                DS_ERR1: begin
                    state     <= DS_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                DS_ERR2: begin
                    if (new_err) begin
                        state     <= DS_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= 1'b1;
                    end else begin
                        state     <= DS_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end
                default: begin
                    state     <= DS_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahblite_interconnect.sv
// ahblite_interconnect
// Single-master AHB-Lite interconnect with four decoded slaves and an
// internal default slave for unmapped addresses.
// Ports:
//   HCLK, HRESETn        : clock, synchronous active-low reset
//   HADDR, HTRANS, HWRITE: master address phase
//   HREADY, HRDATA, HRESP: muxed data-phase response (HREADY also feeds slaves)
//   HSEL_S[3:0]          : one-hot slave selects, combinational from HADDR
//   HREADYOUT_S, HRESP_S : per-slave ready / response
//   HRDATA_S0..S3        : per-slave read data
//   dbg_sel              : data-phase select register, for observation
//   dbg_state            : default-slave FSM state, for observation
module ahblite_interconnect
    import ahblite_interconnect_pkg::*;
#(
    parameter logic [31:0] S0_BASE = DEF_S0_BASE,
    parameter logic [31:0] S0_MASK = DEF_S0_MASK,
    parameter logic [31:0] S1_BASE = DEF_S1_BASE,
    parameter logic [31:0] S1_MASK = DEF_S1_MASK,
    parameter logic [31:0] S2_BASE = DEF_S2_BASE,
    parameter logic [31:0] S2_MASK = DEF_S2_MASK,
    parameter logic [31:0] S3_BASE = DEF_S3_BASE,
    parameter logic [31:0] S3_MASK = DEF_S3_MASK
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    output logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic [3:0]  HSEL_S,
    input  logic [3:0]  HREADYOUT_S,
    input  logic [3:0]  HRESP_S,
    input  logic [31:0] HRDATA_S0,
    input  logic [31:0] HRDATA_S1,
    input  logic [31:0] HRDATA_S2,
    input  logic [31:0] HRDATA_S3,
    output sel_t        dbg_sel,
    output dflt_state_t dbg_state
);

    localparam logic [31:0] BASES [NUM_SLAVES] = '{S0_BASE, S1_BASE, S2_BASE, S3_BASE};
    localparam logic [31:0] MASKS [NUM_SLAVES] = '{S0_MASK, S1_MASK, S2_MASK, S3_MASK};

    sel_t dec_sel;
    sel_t sel_q;
    logic dflt_readyout;
    logic dflt_resp;
    logic unused_hwrite;

    assign unused_hwrite = HWRITE;

    // Scan from the highest index down so the lowest matching index wins.
    always_comb begin
        dec_sel = SEL_DEF;
        for (int n = NUM_SLAVES - 1; n >= 0; n--) begin
            if (addr_match(HADDR, BASES[n], MASKS[n])) begin
                dec_sel = sel_t'(3'(n));
            end
        end
    end

    always_comb begin
        HSEL_S = '0;
        if (dec_sel != SEL_DEF) begin
            HSEL_S[dec_sel[1:0]] = 1'b1;
        end
    end

    // Data-phase target advances only when the current data phase completes,
    // so a stalled slave keeps ownership of the response mux.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            sel_q <= SEL_DEF;
        end else if (HREADY) begin
            sel_q <= dec_sel;
        end
    end

    always_comb begin
        case (sel_q)
            SEL_S0: begin
                HREADY = HREADYOUT_S[0];
                HRESP  = HRESP_S[0];
                HRDATA = HRDATA_S0;
            end
            SEL_S1: begin
                HREADY = HREADYOUT_S[1];
                HRESP  = HRESP_S[1];
                HRDATA = HRDATA_S1;
            end
            SEL_S2: begin
                HREADY = HREADYOUT_S[2];
                HRESP  = HRESP_S[2];
                HRDATA = HRDATA_S2;
            end
            SEL_S3: begin
                HREADY = HREADYOUT_S[3];
                HRESP  = HRESP_S[3];
                HRDATA = HRDATA_S3;
            end
            default: begin
                HREADY = dflt_readyout;
                HRESP  = dflt_resp;
                HRDATA = 32'h0;
            end
        endcase
    end

    ahblite_default_slave u_default (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (dec_sel == SEL_DEF),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HREADYOUT (dflt_readyout),
        .HRESP     (dflt_resp),
        .state     (dbg_state)
    );

    assign dbg_sel = sel_q;

endmodule

// File: tb/tb_ahblite_interconnect.sv
// Testbench for ahblite_interconnect: directed vector table for the
// multi-cycle transfer scenarios, decode-priority checks on an overlapping
// memory map, then randomized traffic against a transaction-level model.
module tb_ahblite_interconnect;
  import ahblite_interconnect_pkg::*;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [31:0] RD0 = 32'h1111_0000;
  localparam logic [31:0] RD1 = 32'h2222_0001;
  localparam logic [31:0] RD2 = 32'h0000_00A5;
  localparam logic [31:0] RD3 = 32'h3333_0003;

  // ---------------- clock / reset ----------------
  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [3:0]  hreadyout_s;
  logic [3:0]  hresp_s;
  logic [31:0] rd [4];

  logic        hready, hresp, ovl_hready, ovl_hresp;
  logic [31:0] hrdata, ovl_hrdata;
  logic [3:0]  hsel_s, ovl_hsel_s;
  sel_t        dbg_sel, ovl_dbg_sel;
  dflt_state_t dbg_state, ovl_dbg_state;

  always #5 hclk = ~hclk;

  ahblite_interconnect dut (
    .HCLK(hclk), .HRESETn(hresetn), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HREADY(hready), .HRDATA(hrdata), .HRESP(hresp), .HSEL_S(hsel_s),
    .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s),
    .HRDATA_S0(rd[0]), .HRDATA_S1(rd[1]), .HRDATA_S2(rd[2]), .HRDATA_S3(rd[3]),
    .dbg_sel(dbg_sel), .dbg_state(dbg_state)
  );

  // Overlapping map: S1 aliases S0, S3 covers S2's window.
  ahblite_interconnect #(
    .S1_BASE(32'h0000_0000), .S1_MASK(32'hFFFF_0000),
    .S3_BASE(32'h4000_0000), .S3_MASK(32'hFFFF_0000)
  ) u_ovl (
    .HCLK(hclk), .HRESETn(hresetn), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HREADY(ovl_hready), .HRDATA(ovl_hrdata), .HRESP(ovl_hresp), .HSEL_S(ovl_hsel_s),
    .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s),
    .HRDATA_S0(rd[0]), .HRDATA_S1(rd[1]), .HRDATA_S2(rd[2]), .HRDATA_S3(rd[3]),
    .dbg_sel(ovl_dbg_sel), .dbg_state(ovl_dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: which target owns the data phase (0..3, 4 = unmapped)
  // and how many ERROR cycles of an unmapped active transfer remain.
  logic [31:0] m_base [4] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h4000_0100};
  logic [31:0] m_mask [4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_FF00};
  int m_dp  = 4;
  int m_err = 0;

  function automatic int ref_decode(input logic [31:0] a);
    for (int n = 0; n < 4; n++)
      if ((a & m_mask[n]) == m_base[n]) return n;
    return 4;
  endfunction

  function automatic logic [3:0] ref_hsel(input logic [31:0] a);
    int t;
    t = ref_decode(a);
    return (t == 4) ? 4'b0000 : 4'(1 << t);
  endfunction

  function automatic logic m_ready();
    if (m_dp < 4) return hreadyout_s[m_dp];
    return m_err != 2;   // first error cycle stalls, second completes
  endfunction

  function automatic logic m_resp();
    if (m_dp < 4) return hresp_s[m_dp];
    return m_err != 0;
  endfunction

  function automatic logic [31:0] m_rdata();
    if (m_dp < 4) return rd[m_dp];
    return 32'h0;
  endfunction

  function automatic dflt_state_t m_state();
    if (m_err == 2) return DS_ERR1;
    if (m_err == 1) return DS_ERR2;
    return DS_IDLE;
  endfunction

  task automatic model_edge();
    if (!hresetn) begin
      m_dp  = 4;
      m_err = 0;
    end else if (m_ready()) begin
      m_dp  = ref_decode(haddr);
      m_err = (m_dp == 4 && htrans[1]) ? 2 : 0;
    end else if (m_err == 2) begin
      m_err = 1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge hclk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic [1:0] t,
                       input logic w, input logic [3:0] ro);
    hresetn     = r;
    haddr       = a;
    htrans      = t;
    hwrite      = w;
    hreadyout_s = ro;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst_n;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [3:0]  hro;
    logic [3:0]  e_hsel;
    logic        e_ready;
    logic        e_resp;
    logic [31:0] e_rdata;
    dflt_state_t e_state;
    sel_t        e_sel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [31:0] a, input logic [1:0] t, input logic w,
                     input logic [3:0] ro, input logic [3:0] hs, input logic rdy, input logic rsp,
                     input logic [31:0] rdat, input dflt_state_t st, input sel_t sl);
    vec_t v;
    v.rst_n = r; v.addr = a; v.trans = t; v.write = w; v.hro = ro;
    v.e_hsel = hs; v.e_ready = rdy; v.e_resp = rsp; v.e_rdata = rdat;
    v.e_state = st; v.e_sel = sl;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] oa [4];
    logic [3:0]  oe [4];

    rd[0] = RD0; rd[1] = RD1; rd[2] = RD2; rd[3] = RD3;
    hresp_s = 4'h0;
    drive(1'b0, 32'h7000_0000, ID, 1'b0, 4'hF);
    tick();
    tick();

    // Each row: inputs for the cycle, outputs expected before the next edge.
    // reset state
    add(0, 32'h7000_0000, ID, 0, 4'hF, 4'b0000, 1, 0, 32'h0, DS_IDLE, SEL_DEF);
    // read from S2
    add(1, 32'h4000_0004, NS, 0, 4'hF, 4'b0100, 1, 0, 32'h0, DS_IDLE, SEL_DEF);
    add(1, 32'h7000_0000, ID, 0, 4'hF, 4'b0000, 1, 0, RD2,   DS_IDLE, SEL_S2);
    // IDLE to unmapped completes OKAY
    add(1, 32'h7000_0000, ID, 0, 4'hF, 4'b0000, 1, 0, 32'h0, DS_IDLE, SEL_DEF);
    // unmapped write -> ERROR, ERROR, then OKAY from S1
    add(1, 32'h5000_0000, NS, 1, 4'hF, 4'b0000, 1, 0, 32'h0, DS_IDLE, SEL_DEF);
    add(1, 32'h2000_0000, ID, 0, 4'hF, 4'b0010, 0, 1, 32'h0, DS_ERR1, SEL_DEF);
    add(1, 32'h2000_0000, ID, 0, 4'hF, 4'b0010, 1, 1, 32'h0, DS_ERR2, SEL_DEF);
    add(1, 32'h7000_0000, ID, 0, 4'hF, 4'b0000, 1, 0, RD1,   DS_IDLE, SEL_S1);
    // S1 stalls three cycles while S2 waits in address phase
    add(1, 32'h2000_0010, NS, 0, 4'hF,    4'b0010, 1, 0, 32'h0, DS_IDLE, SEL_DEF);
    add(1, 32'h4000_0000, NS, 0, 4'b1101, 4'b0100, 0, 0, RD1,   DS_IDLE, SEL_S1);
    add(1, 32'h4000_0000, NS, 0, 4'b1101, 4'b0100, 0, 0, RD1,   DS_IDLE, SEL_S1);
    add(1, 32'h4000_0000, NS, 0, 4'b1101, 4'b0100, 0, 0, RD1,   DS_IDLE, SEL_S1);
    add(1, 32'h4000_0000, NS, 0, 4'hF,    4'b0100, 1, 0, RD1,   DS_IDLE, SEL_S1);
    add(1, 32'h7000_0000, ID, 0, 4'hF,    4'b0000, 1, 0, RD2,   DS_IDLE, SEL_S2);
    // two back-to-back unmapped NONSEQ
    add(1, 32'h6000_0000, NS, 0, 4'hF, 4'b0000, 1, 0, 32'h0, DS_IDLE, SEL_DEF);
    add(1, 32'h6000_0000, NS, 0, 4'hF, 4'b0000, 0, 1, 32'h0, DS_ERR1, SEL_DEF);
    add(1, 32'h6000_0000, NS, 0, 4'hF, 4'b0000, 1, 1, 32'h0, DS_ERR2, SEL_DEF);
    add(1, 32'h7000_0000, ID, 0, 4'hF, 4'b0000, 0, 1, 32'h0, DS_ERR1, SEL_DEF);
    add(1, 32'h7000_0000, ID, 0, 4'hF, 4'b0000, 1, 1, 32'h0, DS_ERR2, SEL_DEF);
    add(1, 32'h7000_0000, ID, 0, 4'hF, 4'b0000, 1, 0, 32'h0, DS_IDLE, SEL_DEF);
    // reset during ERR1 abandons the error
    add(1, 32'h6000_0000, NS, 1, 4'hF, 4'b0000, 1, 0, 32'h0, DS_IDLE, SEL_DEF);
    add(0, 32'h6000_0000, NS, 1, 4'hF, 4'b0000, 0, 1, 32'h0, DS_ERR1, SEL_DEF);
    add(1, 32'h7000_0000, ID, 0, 4'hF, 4'b0000, 1, 0, 32'h0, DS_IDLE, SEL_DEF);
    // unmapped NONSEQ waits behind a stalled S1 before erroring
    add(1, 32'h2000_0000, NS, 0, 4'hF,    4'b0010, 1, 0, 32'h0, DS_IDLE, SEL_DEF);
    add(1, 32'h6000_0000, NS, 0, 4'b1101, 4'b0000, 0, 0, RD1,   DS_IDLE, SEL_S1);
    add(1, 32'h6000_0000, NS, 0, 4'hF,    4'b0000, 1, 0, RD1,   DS_IDLE, SEL_S1);
    add(1, 32'h7000_0000, ID, 0, 4'hF,    4'b0000, 0, 1, 32'h0, DS_ERR1, SEL_DEF);
    add(1, 32'h7000_0000, ID, 0, 4'hF,    4'b0000, 1, 1, 32'h0, DS_ERR2, SEL_DEF);
    add(1, 32'h7000_0000, ID, 0, 4'hF,    4'b0000, 1, 0, 32'h0, DS_IDLE, SEL_DEF);
    // BUSY to unmapped completes OKAY
    add(1, 32'h7000_0000, 2'b01, 0, 4'hF, 4'b0000, 1, 0, 32'h0, DS_IDLE, SEL_DEF);
    add(1, 32'h7000_0000, ID,    0, 4'hF, 4'b0000, 1, 0, 32'h0, DS_IDLE, SEL_DEF);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].addr, vecs[i].trans, vecs[i].write, vecs[i].hro);
      @(negedge hclk);
      chk($sformatf("vec%0d_hsel", i),  32'(hsel_s),    32'(vecs[i].e_hsel));
      chk($sformatf("vec%0d_ready", i), 32'(hready),    32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_resp", i),  32'(hresp),     32'(vecs[i].e_resp));
      chk($sformatf("vec%0d_rdata", i), hrdata,         vecs[i].e_rdata);
      chk($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(vecs[i].e_state));
      chk($sformatf("vec%0d_sel", i),   32'(dbg_sel),   32'(vecs[i].e_sel));
      tick();
    end

    // Decode priority on the overlapping map
    oa[0] = 32'h0000_1234; oe[0] = 4'b0001;
    oa[1] = 32'h2000_0000; oe[1] = 4'b0000;
    oa[2] = 32'h4000_0004; oe[2] = 4'b0100;
    oa[3] = 32'h4000_0104; oe[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, oa[i], ID, 1'b0, 4'hF);
      @(negedge hclk);
      chk($sformatf("ovl%0d_hsel", i), 32'(ovl_hsel_s), 32'(oe[i]));
      tick();
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0: a = {16'h0000, 16'($urandom)};
        1: a = {16'h2000, 16'($urandom)};
        2: a = {24'h400000, 8'($urandom)};
        3: a = {24'h400001, 8'($urandom)};
        4: a = {24'h400002, 8'($urandom)};
        default: a = $urandom;
      endcase
      hresetn = ($urandom_range(0, 63) != 0);
      haddr   = a;
      htrans  = 2'($urandom);
      hwrite  = 1'($urandom);
      for (int n = 0; n < 4; n++) begin
        hreadyout_s[n] = ($urandom_range(0, 3) != 0);
        rd[n]          = $urandom;
      end
      hresp_s = 4'($urandom);
      @(negedge hclk);
      chk("rnd_hsel",  32'(hsel_s),    32'(ref_hsel(haddr)));
      chk("rnd_ready", 32'(hready),    32'(m_ready()));
      chk("rnd_resp",  32'(hresp),     32'(m_resp()));
      chk("rnd_rdata", hrdata,         m_rdata());
      chk("rnd_state", 32'(dbg_state), 32'(m_state()));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahblite_interconnect.md
AHBLITE_INTERCONNECT -- requirements
Module: ahblite_interconnect

Interface
REQ-001 Parameter S0_BASE, 32'h0000_0000, slave 0 base (code/ROM).
REQ-002 Parameter S0_MASK, 32'hFFFF_0000, slave 0 compare mask.
REQ-003 Parameter S1_BASE, 32'h2000_0000, slave 1 base (SRAM).
REQ-004 Parameter S1_MASK, 32'hFFFF_0000, slave 1 compare mask.
REQ-005 Parameter S2_BASE, 32'h4000_0000, slave 2 base (GPIO).
REQ-006 Parameter S2_MASK, 32'hFFFF_FF00, slave 2 compare mask.
REQ-007 Parameter S3_BASE, 32'h4000_0100, slave 3 base (spare peripheral).
REQ-008 Parameter S3_MASK, 32'hFFFF_FF00, slave 3 compare mask.
REQ-009 HCLK  input  1  single system clock; all state on rising edge.
REQ-010 HRESETn  input  1  reset, synchronous, active-low.
REQ-011 HADDR  input  32  master address-phase address.
REQ-012 HTRANS  input  2  master transfer type; bit 1 = NONSEQ/SEQ active.
REQ-013 HWRITE  input  1  master write flag (default-slave use only).
REQ-014 HREADY  output  1  muxed ready, to master and to every slave HREADY input.
REQ-015 HRDATA  output  32  muxed read data to master.
REQ-016 HRESP  output  1  muxed response to master.
REQ-017 HSEL_S  output  4  one-hot slave selects, bit n = slave n.
REQ-018 HREADYOUT_S  input  4  per-slave HREADYOUT, bit n = slave n.
REQ-019 HRESP_S  input  4  per-slave HRESP, bit n = slave n.
REQ-020 HRDATA_S0..HRDATA_S3  input  32 each  per-slave read data.

Function
REQ-021 Decode SHALL be combinational: slave n matches when (HADDR & Sn_MASK) == Sn_BASE.
REQ-022 On multiple matches the lowest index SHALL win; at most one HSEL_S bit SHALL be high.
REQ-023 HSEL_S SHALL follow decode regardless of HTRANS; no match selects the internal default slave (all HSEL_S zero).
REQ-024 Data-phase select register sel_q (encoding S0..S3, DEF) SHALL load the decoded target on every HCLK edge where HREADY=1 and hold when HREADY=0.
REQ-025 HREADY, HRESP, HRDATA SHALL be selected from the slave indicated by sel_q; DEF supplies HRDATA=32'h0.
REQ-026 Default slave FSM states: IDLE, ERR1, ERR2.
REQ-027 IDLE: default HREADYOUT=1, HRESP=0; next ERR1 when default targeted, HTRANS[1]=1, HREADY=1; else IDLE.
REQ-028 ERR1: default HREADYOUT=0, HRESP=1; unconditionally next ERR2.
REQ-029 ERR2: default HREADYOUT=1, HRESP=1; next ERR1 if a new active transfer targets default, else IDLE.
REQ-030 IDLE/BUSY (HTRANS[1]=0) to an unmapped address SHALL complete OKAY, zero wait states.
REQ-031 Latency: mapped transfer adds zero wait states; unmapped active transfer costs exactly two data-phase cycles (ERROR, ERROR).
REQ-032 Back-to-back slaves: address phase of slave B during stalled data phase of slave A SHALL not change sel_q until A's HREADYOUT=1.
REQ-033 HWRITE SHALL not affect default-slave response (reads and writes both ERROR).

Reset
REQ-034 With HRESETn=0 at a rising edge: sel_q=DEF, FSM=IDLE, hence HREADY=1, HRESP=0, HRDATA=0 the following cycle.
REQ-035 Reset asserted mid-transfer (including in ERR1) SHALL abandon it; no pending error survives reset.

Structure
REQ-036 Shared package SHALL hold slave count (4), sel_q encoding, default-slave state enum, and default base/mask constants.
REQ-037 Default slave SHALL be a sub-module ahblite_default_slave (ports HCLK, HRESETn, HSEL, HTRANS, HREADY, HREADYOUT, HRESP).

Verification
REQ-038 NONSEQ read HADDR=32'h4000_0004, HRDATA_S2=32'h0000_00A5 -> HSEL_S=4'b0100, next cycle HRDATA=32'h0000_00A5, HRESP=0, HREADY=1.
REQ-039 NONSEQ write HADDR=32'h5000_0000 -> HSEL_S=0, data phase HREADY=0/HRESP=1 then HREADY=1/HRESP=1, then OKAY.
REQ-040 Read S1 at 32'h2000_0010 with HREADYOUT_S[1] low 3 cycles, next address 32'h4000_0000 -> HREADY low 3 cycles, sel_q stays S1, then HRDATA from S1, then S2.
REQ-041 Two consecutive NONSEQ to 32'h6000_0000 -> ERR1,ERR2,ERR1,ERR2,IDLE; four data-phase cycles total.
REQ-042 IDLE HTRANS to 32'h7000_0000 -> HREADY=1, HRESP=0, FSM stays IDLE.
REQ-043 HRESETn low during ERR1 -> next cycle HREADY=1, HRESP=0, HRDATA=0, FSM IDLE.
